sdram_access_arbiter: RTL and testbench
=======================================

Name: sdram_access_arbiter

Overview:
Time-shares the single SDRAM command port between three requesters: auto-refresh, TFT display line fetch, and the user-interface single-entry write FIFO (FIFO_full/FIFO_data/FIFO_RD_req, row_add/col_add, page_set). It issues one command at a time to the SDRAM controller. It acknowledges the winning requester on completion and advances the user write address via startup_inc. It sits between the user command block, the TFT line-buffer logic, the refresh timer and the SDRAM controller.

Parameters:
MAX_WAIT, 4, consecutive display grants allowed while a user write is pending before the write is forced through.
WAIT_W, 3, width of the starvation counter; must hold MAX_WAIT.
DISP_BURST, 800, words per display line read; sets ctrl_len for reads.

Ports:
osc_clk  in  1  system clock, all logic on rising edge
RST  in  1  asynchronous reset, active-high
ref_req  in  1  refresh request, level, held until ref_ack
ref_ack  out  1  one-cycle pulse, refresh finished
disp_req  in  1  display line fetch request, level, held until disp_done
disp_row  in  9  display row to fetch (0..479)
disp_page  in  3  display page (page_show)
disp_done  out  1  one-cycle pulse, line read finished
FIFO_full  in  1  user write word pending
FIFO_data  in  16  user write word
page_set  in  3  user write page
row_add  in  9  user write row
col_add  in  10  user write column
FIFO_RD_req  out  1  one-cycle pulse, pending word consumed
startup_inc  out  1  one-cycle pulse, advance user address; coincident with FIFO_RD_req
ctrl_valid  out  1  command valid to SDRAM controller
ctrl_ready  in  1  controller accepts command when high with ctrl_valid
ctrl_cmd  out  2  00 idle, 01 write, 10 read burst, 11 refresh
ctrl_addr  out  22  {page[2:0], row[8:0], col[9:0]}
ctrl_len  out  10  write 1, read DISP_BURST, refresh 0
ctrl_wdata  out  16  write data
ctrl_done  in  1  one-cycle pulse, command completed
grant_id  out  2  00 none, 01 write, 10 display, 11 refresh; drives datapath muxes
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE. All pulses 0. ctrl_valid 0, ctrl_cmd 00, ctrl_addr/ctrl_len/ctrl_wdata 0, grant_id 00, busy 0, wait counter 0. Reset asserted mid-command drops ctrl_valid immediately and abandons the command without acknowledging any requester.
- States: IDLE, ISSUE, WAIT, RELEASE.
- IDLE, priority:
  1. ref_req.
  2. FIFO_full if wait counter == MAX_WAIT.
  3. disp_req.
  4. FIFO_full.
  On a winner: latch cmd, addr, len, wdata (FIFO_data for a write), set grant_id, assert ctrl_valid; go ISSUE. Command appears 1 cycle after the request is sampled. With no request, stay in IDLE.
- ISSUE: hold ctrl_valid and all command fields stable until ctrl_ready is sampled high. On that edge drop ctrl_valid and go WAIT. No upper bound on the wait.
- WAIT: on ctrl_done go RELEASE and register the winner's pulse for exactly the RELEASE cycle:
  - write: FIFO_RD_req and startup_inc together.
  - display: disp_done.
  - refresh: ref_ack.
  ctrl_done seen in ISSUE is ignored.
- RELEASE: one cycle, then IDLE; clear grant_id. This guarantees FIFO_full/disp_req/ref_req are deasserted by the requester before re-arbitration, so no double-serve.
- Starvation counter:
  - +1 (saturating at MAX_WAIT) on each display grant made while FIFO_full is high.
  - Cleared on a write grant.
  - Held when FIFO_full is low.
- Refresh is never delayed by the counter. Requests arriving while busy wait for IDLE. Simultaneous ref_req, disp_req and FIFO_full: refresh wins, then priority resolves on the next IDLE.
- Address wrap/advance is owned by the user block; this block only pulses startup_inc once per completed write.

Test Plan:
- Reset with all requests high, then RST low → ref_req wins first. Sequence: ctrl_cmd=11, ctrl_len=0, grant_id=11; ref_ack pulses 1 cycle in RELEASE.
- FIFO_full=1, FIFO_data=16'hA5C3, page_set=2, row_add=10, col_add=5, ctrl_ready after 3 cycles, ctrl_done 4 cycles later → ctrl_addr={3'd2,9'd10,10'd5}, ctrl_wdata=A5C3, ctrl_len=1, valid held 3 cycles; FIFO_RD_req and startup_inc high together for exactly 1 cycle; no second write grant.
- disp_req and FIFO_full held continuously → four display reads (ctrl_len=800, addr={disp_page,disp_row,0}), then a write. Counter clears and display resumes.
- ref_req rises during a display WAIT → display completes with disp_done; refresh is issued next, before a pending write.
- RST asserted while in ISSUE with ctrl_valid=1 → ctrl_valid=0 asynchronously; no FIFO_RD_req, disp_done or ref_ack after release of reset.
- ctrl_done pulsed while in ISSUE → ignored; state stays ISSUE until ctrl_ready.

Source files
------------

// File: rtl/sdram_access_arbiter.sv
// rtl/sdram_access_arbiter.sv - time-shares the SDRAM command port between refresh, display fetch and user writes
// One command in flight at a time; the winner is acknowledged after ctrl_done, in a one-cycle RELEASE slot.
module sdram_access_arbiter #(
    parameter int MAX_WAIT   = 4,
    parameter int WAIT_W     = 3,
    parameter int DISP_BURST = 800
) (
    input  logic        osc_clk,
    input  logic        RST,
    input  logic        ref_req,
    output logic        ref_ack,
    input  logic        disp_req,
    input  logic [8:0]  disp_row,
    input  logic [2:0]  disp_page,
    output logic        disp_done,
    input  logic        FIFO_full,
    input  logic [15:0] FIFO_data,
    input  logic [2:0]  page_set,
    input  logic [8:0]  row_add,
    input  logic [9:0]  col_add,
    output logic        FIFO_RD_req,
    output logic        startup_inc,
    output logic        ctrl_valid,
    input  logic        ctrl_ready,
    output logic [1:0]  ctrl_cmd,
    output logic [21:0] ctrl_addr,
    output logic [9:0]  ctrl_len,
    output logic [15:0] ctrl_wdata,
    input  logic        ctrl_done,
    output logic [1:0]  grant_id,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // Grant codes double as controller command codes.
    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_WR   = 2'b01;
    localparam logic [1:0] G_DISP = 2'b10;
    localparam logic [1:0] G_REF  = 2'b11;

    localparam logic [WAIT_W-1:0] L_MAX_WAIT = WAIT_W'(MAX_WAIT);
    localparam logic [9:0]        L_BURST    = 10'(DISP_BURST);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        w_win;
    logic              w_force_write;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_ctrl_valid;
    logic [1:0]        r_ctrl_cmd;
    logic [21:0]       r_ctrl_addr;
    logic [9:0]        r_ctrl_len;
    logic [15:0]       r_ctrl_wdata;
    logic [1:0]        r_grant_id;
    logic              r_ref_ack;
    logic              r_disp_done;
    logic              r_fifo_rd;

    assign w_force_write = FIFO_full && (r_wait_cnt == L_MAX_WAIT);

    always_comb begin
        w_state_nxt = r_state;
        w_win       = G_NONE;
        case (r_state)
            S_IDLE: begin
                if (ref_req)            w_win = G_REF;
                else if (w_force_write) w_win = G_WR;
                else if (disp_req)      w_win = G_DISP;
                else if (FIFO_full)     w_win = G_WR;
                if (w_win != G_NONE)    w_state_nxt = S_ISSUE;
            end
            S_ISSUE:   if (ctrl_ready) w_state_nxt = S_WAIT;
            S_WAIT:    if (ctrl_done)  w_state_nxt = S_RELEASE;
            S_RELEASE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge osc_clk or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge osc_clk or posedge RST) begin
        if (RST) begin
            r_wait_cnt   <= '0;
            r_ctrl_valid <= 1'b0;
            r_ctrl_cmd   <= G_NONE;
            r_ctrl_addr  <= '0;
            r_ctrl_len   <= '0;
            r_ctrl_wdata <= '0;
            r_grant_id   <= G_NONE;
            r_ref_ack    <= 1'b0;
            r_disp_done  <= 1'b0;
            r_fifo_rd    <= 1'b0;
        end else begin
            r_ref_ack   <= 1'b0;
            r_disp_done <= 1'b0;
            r_fifo_rd   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_win != G_NONE) begin
                        r_ctrl_valid <= 1'b1;
                        r_ctrl_cmd   <= w_win;
                        r_grant_id   <= w_win;
                    end
                    case (w_win)
                        G_REF: begin
                            r_ctrl_addr  <= '0;
                            r_ctrl_len   <= '0;
                            r_ctrl_wdata <= '0;
                        end
                        G_WR: begin
                            r_ctrl_addr  <= {page_set, row_add, col_add};
                            r_ctrl_len   <= 10'd1;
                            r_ctrl_wdata <= FIFO_data;
                            r_wait_cnt   <= '0;
                        end
                        G_DISP: begin
                            r_ctrl_addr  <= {disp_page, disp_row, 10'd0};
                            r_ctrl_len   <= L_BURST;
                            r_ctrl_wdata <= '0;
                            // Only display grants that overtake a pending write count toward starvation.
                            if (FIFO_full && (r_wait_cnt != L_MAX_WAIT))
                                r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_ISSUE: if (ctrl_ready) r_ctrl_valid <= 1'b0;
                S_WAIT: begin
                    if (ctrl_done) begin
                        r_fifo_rd   <= (r_grant_id == G_WR);
                        r_disp_done <= (r_grant_id == G_DISP);
                        r_ref_ack   <= (r_grant_id == G_REF);
                    end
                end
                S_RELEASE: begin
                    r_grant_id   <= G_NONE;
                    r_ctrl_cmd   <= G_NONE;
                    r_ctrl_addr  <= '0;
                    r_ctrl_len   <= '0;
                    r_ctrl_wdata <= '0;
                end
                default: ;
            endcase
        end
    end

    assign ctrl_valid  = r_ctrl_valid;
    assign ctrl_cmd    = r_ctrl_cmd;
    assign ctrl_addr   = r_ctrl_addr;
    assign ctrl_len    = r_ctrl_len;
    assign ctrl_wdata  = r_ctrl_wdata;
    assign grant_id    = r_grant_id;
    assign ref_ack     = r_ref_ack;
    assign disp_done   = r_disp_done;
    assign FIFO_RD_req = r_fifo_rd;
    assign startup_inc = r_fifo_rd;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// tb/tb_sdram_access_arbiter.sv - directed self-checking bench for sdram_access_arbiter
module tb_sdram_access_arbiter;

    logic        osc_clk = 1'b0;
    logic        RST;
    logic        ref_req, ref_ack;
    logic        disp_req;
    logic [8:0]  disp_row;
    logic [2:0]  disp_page;
    logic        disp_done;
    logic        FIFO_full;
    logic [15:0] FIFO_data;
    logic [2:0]  page_set;
    logic [8:0]  row_add;
    logic [9:0]  col_add;
    logic        FIFO_RD_req, startup_inc;
    logic        ctrl_valid, ctrl_ready, ctrl_done;
    logic [1:0]  ctrl_cmd;
    logic [21:0] ctrl_addr;
    logic [9:0]  ctrl_len;
    logic [15:0] ctrl_wdata;
    logic [1:0]  grant_id;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int n_ref = 0, n_disp = 0, n_wr = 0, n_pair_bad = 0;

    always #5 osc_clk = ~osc_clk;

    sdram_access_arbiter dut (
        .osc_clk(osc_clk), .RST(RST),
        .ref_req(ref_req), .ref_ack(ref_ack),
        .disp_req(disp_req), .disp_row(disp_row), .disp_page(disp_page), .disp_done(disp_done),
        .FIFO_full(FIFO_full), .FIFO_data(FIFO_data), .page_set(page_set),
        .row_add(row_add), .col_add(col_add),
        .FIFO_RD_req(FIFO_RD_req), .startup_inc(startup_inc),
        .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .ctrl_cmd(ctrl_cmd),
        .ctrl_addr(ctrl_addr), .ctrl_len(ctrl_len), .ctrl_wdata(ctrl_wdata),
        .ctrl_done(ctrl_done), .grant_id(grant_id), .busy(busy)
    );

    always @(negedge osc_clk) begin
        if (ref_ack)     n_ref++;
        if (disp_done)   n_disp++;
        if (FIFO_RD_req) n_wr++;
        if (FIFO_RD_req !== startup_inc) n_pair_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge osc_clk);
        #1;
    endtask

    // Entered one step after the edge that raised ctrl_valid; leaves in the RELEASE cycle.
    task automatic serve(input logic [1:0] exp_cmd, input int rdy, input int dn,
                         input bit ref_in_wait, output int vcnt);
        vcnt = 0;
        for (int i = 0; i < rdy; i++) begin
            if (ctrl_valid) vcnt++;
            check("hold_cmd", {30'd0, ctrl_cmd}, {30'd0, exp_cmd});
            if (i == rdy - 1) ctrl_ready = 1'b1;
            tick();
        end
        ctrl_ready = 1'b0;
        check("valid_drop", {31'd0, ctrl_valid}, 32'd0);
        if (ref_in_wait) ref_req = 1'b1;
        for (int i = 1; i < dn; i++) tick();
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
    endtask

    int v;
    int s_ref, s_disp, s_wr;
    logic [21:0] e_addr;

    initial begin
        RST = 1'b0; ref_req = 1'b0; disp_req = 1'b0; FIFO_full = 1'b0;
        disp_row = 9'd0; disp_page = 3'd0; FIFO_data = 16'd0;
        page_set = 3'd0; row_add = 9'd0; col_add = 10'd0;
        ctrl_ready = 1'b0; ctrl_done = 1'b0;
        #2 RST = 1'b1;
        ref_req = 1'b1; disp_req = 1'b1; FIFO_full = 1'b1;
        repeat (2) @(posedge osc_clk);
        #1;
        check("rst_valid", {31'd0, ctrl_valid}, 32'd0);
        check("rst_cmd",   {30'd0, ctrl_cmd}, 32'd0);
        check("rst_grant", {30'd0, grant_id}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_fields", {ctrl_len, ctrl_addr}, 32'd0);
        check("rst_pulses", {28'd0, ref_ack, disp_done, FIFO_RD_req, startup_inc}, 32'd0);

        // Refresh wins with everything pending.
        RST = 1'b0;
        tick();
        check("t1_valid", {31'd0, ctrl_valid}, 32'd1);
        check("t1_cmd",   {30'd0, ctrl_cmd}, 32'd3);
        check("t1_len",   {22'd0, ctrl_len}, 32'd0);
        check("t1_grant", {30'd0, grant_id}, 32'd3);
        serve(2'b11, 1, 1, 1'b0, v);
        check("t1_ref_ack", {29'd0, ref_ack, disp_done, FIFO_RD_req}, 32'b100);
        ref_req = 1'b0; disp_req = 1'b0; FIFO_full = 1'b0;
        tick();
        check("t1_idle", {29'd0, ref_ack, grant_id}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd0);
        tick();
        check("t1_no_cmd", {31'd0, ctrl_valid}, 32'd0);

        // Single user write with slow ready/done.
        FIFO_full = 1'b1; FIFO_data = 16'hA5C3; page_set = 3'd2; row_add = 9'd10; col_add = 10'd5;
        tick();
        e_addr = {3'd2, 9'd10, 10'd5};
        check("t2_cmd",   {30'd0, ctrl_cmd}, 32'd1);
        check("t2_addr",  {10'd0, ctrl_addr}, {10'd0, e_addr});
        check("t2_wdata", {16'd0, ctrl_wdata}, 32'h0000A5C3);
        check("t2_len",   {22'd0, ctrl_len}, 32'd1);
        check("t2_grant", {30'd0, grant_id}, 32'd1);
        serve(2'b01, 3, 4, 1'b0, v);
        check("t2_valid_cycles", v, 32'd3);
        check("t2_rd_inc", {30'd0, FIFO_RD_req, startup_inc}, 32'b11);
        FIFO_full = 1'b0;
        tick();
        check("t2_rd_width", {31'd0, FIFO_RD_req}, 32'd0);
        tick(); tick();
        check("t2_no_regrant", {31'd0, ctrl_valid}, 32'd0);

        // Starvation: four display grants, then a forced write, then display resumes.
        disp_page = 3'd5; disp_row = 9'd479; disp_req = 1'b1;
        FIFO_full = 1'b1; FIFO_data = 16'h1234; page_set = 3'd1; row_add = 9'd2; col_add = 10'd3;
        e_addr = {3'd5, 9'd479, 10'd0};
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 4) begin
                check("t3_cmd_wr", {30'd0, ctrl_cmd}, 32'd1);
                check("t3_wdata",  {16'd0, ctrl_wdata}, 32'h00001234);
                serve(2'b01, 2, 2, 1'b0, v);
                check("t3_rd", {31'd0, FIFO_RD_req}, 32'd1);
            end else begin
                check("t3_cmd_rd", {30'd0, ctrl_cmd}, 32'd2);
                check("t3_len",    {22'd0, ctrl_len}, 32'd800);
                check("t3_addr",   {10'd0, ctrl_addr}, {10'd0, e_addr});
                serve(2'b10, 2, 2, 1'b0, v);
                check("t3_done", {31'd0, disp_done}, 32'd1);
            end
            if (k == 5) begin
                disp_req = 1'b0; FIFO_full = 1'b0;
            end
            tick();
        end

        // Refresh raised mid-display goes ahead of the pending write.
        disp_row = 9'd100; disp_req = 1'b1; FIFO_full = 1'b1; FIFO_data = 16'hBEEF;
        tick();
        check("t4_cmd_rd", {30'd0, ctrl_cmd}, 32'd2);
        serve(2'b10, 1, 3, 1'b1, v);
        check("t4_done", {30'd0, disp_done, ref_ack}, 32'b10);
        disp_req = 1'b0;
        tick();
        tick();
        check("t4_cmd_ref", {30'd0, ctrl_cmd}, 32'd3);
        serve(2'b11, 1, 1, 1'b0, v);
        check("t4_ref_ack", {31'd0, ref_ack}, 32'd1);
        ref_req = 1'b0;
        tick();
        tick();
        check("t4_cmd_wr", {30'd0, ctrl_cmd}, 32'd1);
        check("t4_wdata",  {16'd0, ctrl_wdata}, 32'h0000BEEF);
        serve(2'b01, 1, 1, 1'b0, v);
        check("t4_rd", {31'd0, FIFO_RD_req}, 32'd1);
        FIFO_full = 1'b0;
        tick();

        // ctrl_done while still in ISSUE is ignored.
        FIFO_full = 1'b1; FIFO_data = 16'h0F0F;
        tick();
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        check("t6_valid", {31'd0, ctrl_valid}, 32'd1);
        check("t6_busy_cmd", {29'd0, busy, ctrl_cmd}, 32'b101);
        tick();
        check("t6_no_rd", {30'd0, FIFO_RD_req, ctrl_valid}, 32'b01);
        serve(2'b01, 2, 2, 1'b0, v);
        check("t6_rd", {31'd0, FIFO_RD_req}, 32'd1);
        FIFO_full = 1'b0;
        tick();

        // Asynchronous reset during ISSUE abandons the command.
        s_ref = n_ref; s_disp = n_disp; s_wr = n_wr;
        FIFO_full = 1'b1; FIFO_data = 16'h7777;
        tick();
        check("t5_valid_pre", {31'd0, ctrl_valid}, 32'd1);
        #2 RST = 1'b1;
        #1;
        check("t5_valid_async", {31'd0, ctrl_valid}, 32'd0);
        check("t5_grant_busy", {29'd0, busy, grant_id}, 32'd0);
        FIFO_full = 1'b0;
        tick();
        RST = 1'b0;
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        repeat (4) tick();
        check("t5_no_valid", {31'd0, ctrl_valid}, 32'd0);
        check("t5_no_ack", n_ref + n_disp + n_wr - s_ref - s_disp - s_wr, 32'd0);

        check("tot_ref_acks", n_ref, 32'd2);
        check("tot_disp_done", n_disp, 32'd6);
        check("tot_writes", n_wr, 32'd4);
        check("rd_inc_pairing", n_pair_bad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
